display_scanout: RTL and testbench
==================================

Name: display_scanout

Overview:
- Downstream read stage of the frame buffer. Generates raster timing with a 100x100 active window by default.
- Issues read-enable and linear address to the buffer's read port, and absorbs the buffer's 1-cycle registered read latency.
- Drives aligned RGB, de, hsync and vsync to the display PHY.
- Controls which of the two ping-pong buffers is scanned; buffer selection switches only at frame boundaries.

Parameters:
- H_ACTIVE, 100, active pixels per line
- H_FP, 4, horizontal front porch (clocks)
- H_SYNC, 8, hsync pulse width (clocks)
- H_BP, 4, horizontal back porch (clocks)
- V_ACTIVE, 100, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- ADDR_W, 20, buffer address width

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- swap_req  in  1  level request to switch buffers at the next frame end
- R_in  in  8  buffer read data, red
- G_in  in  8  buffer read data, green
- B_in  in  8  buffer read data, blue
- RE  out  1  buffer read enable
- Addr  out  ADDR_W  buffer read address
- buf_sel  out  1  buffer currently scanned (0/1)
- swap_ack  out  1  1-cycle pulse when buf_sel toggles
- frame_done  out  1  1-cycle pulse at the last counter position of a frame
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  active video
- R_out  out  8  red pixel output
- G_out  out  8  green pixel output
- B_out  out  8  blue pixel output

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (116). V_TOTAL likewise (106). Frame = 12296 clocks.
- Reset (asynchronous, reset=0):
  - Counters, address counter and all pipeline registers clear.
  - RE=0, Addr=0, de=0, RGB=0, hsync=1, vsync=1, buf_sel=0, swap_ack=0, frame_done=0.
  - Reset mid-frame aborts the frame; scan restarts at h=0, v=0.
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1):
  - en=0: synchronously forced to 0. Pipeline drains to blank; sync outputs go inactive.
  - en=1: h_cnt increments every clock and wraps to 0.
  - On the h_cnt wrap, v_cnt increments and wraps at V_TOTAL-1.
  - The first counted position is (0,0) on the first clock with en=1.
- active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- addr_cnt:
  - Increments only on active cycles.
  - Clears when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
  - No multiplier: Addr = v*H_ACTIVE+h by construction.
  - Range 0..9999.
- Stage 1 (registered, counter cycle t+1): RE=active, Addr=addr_cnt.
- Stage 2 (registered, t+3 at the pins):
  - de, hsync and vsync are delayed so they align with the returned data.
  - R/G/B_out = de_pipe ? R/G/B_in : 0.
  - Latency: counter position to pins = 3 clocks; RE to RGB_out = 2 clocks.
- hsync=0 when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync=0 when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), across the full line.
- frame_done:
  - Generated at counter position (H_TOTAL-1, V_TOTAL-1).
  - Registered; not pipeline-delayed.
- Swap:
  - At the frame_done position with swap_req=1: buf_sel toggles and swap_ack=1 for that same clock.
  - Otherwise buf_sel holds.
  - swap_req held high across frames toggles once per frame.
  - No mid-frame toggle ever occurs.
- RE is never asserted outside the active window. Addr holds its last value when RE=0.
- The writer must target buffer !buf_sel; the buffer ignores a read when its write enable is also set.

Optional Feature:
- Macro: SCANOUT_TESTPATTERN_EN.
- Defined: adds input pattern_sel (1 bit).
  - pattern_sel=1: RGB is replaced at stage 2 by 8 vertical colour bars (bar = delayed h_cnt*8/H_ACTIVE).
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black; components are 0xFF/0x00.
  - RE stays 0 throughout.
  - Timing is unchanged.
- Undefined: no pattern_sel port; RGB always comes from the buffer.

Decomposition:
- Package display_pkg:
  - PIX_W=8, ADDR_W=20, default timing constants, H_TOTAL/V_TOTAL localparams.
  - rgb_t packed struct {r,g,b}.
  - Sync polarity constant (active-low).
- Sub-module scan_timing_gen: h/v counters, active, addr_cnt, raw sync, frame end.
- display_scanout: adds the latency pipeline, swap logic and pattern mux.

Test Plan:
- Reset release, en=1, buffer model returns {R=A[7:0], G=A[15:8], B=0x5A} one clock after RE:
  - First de=1 three clocks after en.
  - Pixel 0 is (0x00, 0x00, 0x5A).
  - Addr runs 0..99 on line 0 and 100 at the start of line 1.
- Sync check:
  - hsync low for exactly 8 clocks per line, beginning 104 clocks after line start (pin timing +3).
  - vsync low during lines 102-103 (232 clocks).
  - de=0 for the whole vsync period.
- Frame wrap:
  - Last RE has Addr=9999.
  - Next frame's first RE has Addr=0.
  - frame_done pulses exactly every 12296 clocks.
  - 10000 RE cycles per frame.
- Swap:
  - swap_req=1 mid-frame → buf_sel unchanged until the frame_done clock, toggles with a 1-clock swap_ack.
  - swap_req=0 over two frames → no toggle.
- Reset=0 at line 50, pixel 30:
  - Outputs immediately RGB=0, de=0, hsync/vsync=1.
  - After release, Addr restarts at 0.
- en drop mid-line → within 3 clocks de=0, RE=0, syncs high; re-enable restarts at (0,0).
- SCANOUT_TESTPATTERN_EN, pattern_sel=1 → line 0 pixels 0-12 white, 13-24 yellow, …, last bar black; RE never asserted.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and default raster timing for the frame-buffer scan-out path.
package display_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 20;

  localparam int unsigned H_ACTIVE_DEF = 100;
  localparam int unsigned H_FP_DEF     = 4;
  localparam int unsigned H_SYNC_DEF   = 8;
  localparam int unsigned H_BP_DEF     = 4;
  localparam int unsigned V_ACTIVE_DEF = 100;
  localparam int unsigned V_FP_DEF     = 2;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 2;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Both syncs are active-low.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_colour(input logic [2:0] bar);
    logic [2:0] m;
    rgb_t       c;
    unique case (bar)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    c.r = {PIX_W{m[2]}};
    c.g = {PIX_W{m[1]}};
    c.b = {PIX_W{m[0]}};
    return c;
  endfunction

endpackage

// File: rtl/scan_timing_gen.sv
// Raster counters: h/v position, active window, linear read address, raw syncs, frame end.
module scan_timing_gen
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned ADDR_W   = display_pkg::ADDR_W,
  localparam int unsigned H_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  output logic              o_active,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_frame_end,
  output logic [H_W-1:0]    o_h,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int unsigned HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_W = $clog2(VT);

  localparam logic [H_W-1:0] H_LAST = H_W'(HT - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(VT - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [ADDR_W-1:0] r_addr;
  logic              w_h_last, w_v_last, w_active;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  // Counters sit at (0,0) while disabled, so that position is only counted once enabled.
  assign w_active = i_en && (r_h < H_ACT) && (r_v < V_ACT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h    <= '0;
      r_v    <= '0;
      r_addr <= '0;
    end else if (!i_en) begin
      r_h    <= '0;
      r_v    <= '0;
      r_addr <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
      // Counting only active pixels yields v*H_ACTIVE+h without a multiplier.
      if (w_h_last && w_v_last) r_addr <= '0;
      else if (w_active)        r_addr <= r_addr + 1'b1;
    end
  end

  assign o_active    = w_active;
  assign o_h         = r_h;
  assign o_addr      = r_addr;
  assign o_frame_end = i_en && w_h_last && w_v_last;
  assign o_hsync     = (i_en && (r_h >= HS_BEG) && (r_h < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_vsync     = (i_en && (r_v >= VS_BEG) && (r_v < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: rtl/display_scanout.sv
// Frame-buffer scan-out: read issue, 1-cycle read-latency alignment, ping-pong buffer select.
// Optional colour-bar generator enabled by SCANOUT_TESTPATTERN_EN (adds i_pattern_sel).
module display_scanout
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned ADDR_W   = display_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_swap_req,
`ifdef SCANOUT_TESTPATTERN_EN
  input  logic              i_pattern_sel,
`endif
  input  logic [PIX_W-1:0]  i_r,
  input  logic [PIX_W-1:0]  i_g,
  input  logic [PIX_W-1:0]  i_b,
  output logic              o_re,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_buf_sel,
  output logic              o_swap_ack,
  output logic              o_frame_done,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [PIX_W-1:0]  o_r,
  output logic [PIX_W-1:0]  o_g,
  output logic [PIX_W-1:0]  o_b
);

  localparam int unsigned H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

  logic              w_active, w_hsync, w_vsync, w_frame_end, w_pat_sel, w_issue;
  logic [H_W-1:0]    w_h;
  logic [ADDR_W-1:0] w_addr;
  rgb_t              w_buf, w_pix;

  scan_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .ADDR_W   (ADDR_W)
  ) u_timing (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .o_active    (w_active),
    .o_hsync     (w_hsync),
    .o_vsync     (w_vsync),
    .o_frame_end (w_frame_end),
    .o_h         (w_h),
    .o_addr      (w_addr)
  );

`ifdef SCANOUT_TESTPATTERN_EN
  assign w_pat_sel = i_pattern_sel;
`else
  assign w_pat_sel = 1'b0;
`endif

  // No buffer reads while the internal pattern replaces the picture.
  assign w_issue = w_active && !w_pat_sel;

  logic              r_re;
  logic [ADDR_W-1:0] r_addr;
  logic              r_de1, r_hs1, r_vs1, r_pat1;
  logic              r_de2, r_hs2, r_vs2, r_pat2;
  logic [H_W-1:0]    r_h1, r_h2;
  logic              r_de, r_hs, r_vs;
  rgb_t              r_rgb;
  logic              r_buf_sel, r_swap_ack, r_frame_done;

  assign w_buf = '{r: i_r, g: i_g, b: i_b};

`ifdef SCANOUT_TESTPATTERN_EN
  logic [2:0] w_bar;
  assign w_bar = 3'((32'(r_h2) * 32'd8) / H_ACTIVE);
  assign w_pix = r_pat2 ? bar_colour(w_bar) : w_buf;
`else
  logic w_unused_pipe;
  assign w_unused_pipe = ^{r_h2, r_pat2};
  assign w_pix         = w_buf;
`endif

  // Stage 1 issues the read; stage 2 waits for the buffer; stage 3 drives the pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_re   <= 1'b0;
      r_addr <= '0;
      r_de1  <= 1'b0;
      r_hs1  <= ~SYNC_ACTIVE;
      r_vs1  <= ~SYNC_ACTIVE;
      r_pat1 <= 1'b0;
      r_h1   <= '0;
      r_de2  <= 1'b0;
      r_hs2  <= ~SYNC_ACTIVE;
      r_vs2  <= ~SYNC_ACTIVE;
      r_pat2 <= 1'b0;
      r_h2   <= '0;
      r_de   <= 1'b0;
      r_hs   <= ~SYNC_ACTIVE;
      r_vs   <= ~SYNC_ACTIVE;
      r_rgb  <= '0;
    end else begin
      r_re <= w_issue;
      if (w_issue) r_addr <= w_addr;
      r_de1  <= w_active;
      r_hs1  <= w_hsync;
      r_vs1  <= w_vsync;
      r_pat1 <= w_pat_sel;
      r_h1   <= w_h;
      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_pat2 <= r_pat1;
      r_h2   <= r_h1;
      r_de   <= r_de2;
      r_hs   <= r_hs2;
      r_vs   <= r_vs2;
      r_rgb  <= r_de2 ? w_pix : '0;
    end
  end

  // Buffer selection may only change on the last counter position of a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf_sel    <= 1'b0;
      r_swap_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_swap_ack   <= w_frame_end && i_swap_req;
      if (w_frame_end && i_swap_req) r_buf_sel <= ~r_buf_sel;
    end
  end

  assign o_re         = r_re;
  assign o_addr       = r_addr;
  assign o_de         = r_de;
  assign o_hsync      = r_hs;
  assign o_vsync      = r_vs;
  assign o_r          = r_rgb.r;
  assign o_g          = r_rgb.g;
  assign o_b          = r_rgb.b;
  assign o_buf_sel    = r_buf_sel;
  assign o_swap_ack   = r_swap_ack;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanout.sv
// Randomised scoreboard bench for display_scanout against a frame-position reference model.
module tb_display_scanout;

  localparam int unsigned HA    = 100;
  localparam int unsigned HT    = 116;
  localparam int unsigned VA    = 100;
  localparam int unsigned VT    = 106;
  localparam int unsigned FRAME = HT * VT;

  logic        clk, rst_n, en, swap_req, pat_sel;
  logic [7:0]  r_in, g_in, b_in;
  logic        re, buf_sel, swap_ack, frame_done, hsync, vsync, de;
  logic [19:0] addr;
  logic [7:0]  r_out, g_out, b_out;

  display_scanout u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_swap_req    (swap_req),
`ifdef SCANOUT_TESTPATTERN_EN
    .i_pattern_sel (pat_sel),
`endif
    .i_r           (r_in),
    .i_g           (g_in),
    .i_b           (b_in),
    .o_re          (re),
    .o_addr        (addr),
    .o_buf_sel     (buf_sel),
    .o_swap_ack    (swap_ack),
    .o_frame_done  (frame_done),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_de          (de),
    .o_r           (r_out),
    .o_g           (g_out),
    .o_b           (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer read port: registered, one clock of latency.
  initial begin
    r_in = 8'h00;
    g_in = 8'h00;
    b_in = 8'h00;
  end
  always @(posedge clk) begin
    if (re) begin
      r_in <= addr[7:0];
      g_in <= addr[15:8];
      b_in <= 8'h5A;
    end
  end

  typedef struct {
    int unsigned due;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } pin_t;
  typedef struct {
    int unsigned due;
    int unsigned addr;
  } re_t;
  typedef struct {
    int unsigned due;
    logic        ack;
  } ctl_t;

  pin_t pin_q[$];
  re_t  re_q[$];
  ctl_t ctl_q[$];

  logic [23:0] bars [8];
  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
  end

  int unsigned total, bad;
  int unsigned cyc, k;
  int unsigned last_addr;
  logic        exp_sel;
  int unsigned last_fd_cyc, re_cnt;
  logic        seg_ok, pat_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor and model: compare what is due this cycle, then predict from this cycle's inputs.
  pin_t        ep;
  logic        e_re, e_fd, e_ack, act_pos, hs_e, vs_e;
  int unsigned h, v, a;
  logic [19:0] aw;
  logic [23:0] pix;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_re", 32'(re), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_de", 32'(de), 0);
      chk("rst_rgb", {8'h0, r_out, g_out, b_out}, 0);
      chk("rst_hsync", 32'(hsync), 1);
      chk("rst_vsync", 32'(vsync), 1);
      chk("rst_buf_sel", 32'(buf_sel), 0);
      chk("rst_swap_ack", 32'(swap_ack), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      pin_q.delete();
      re_q.delete();
      ctl_q.delete();
      k         = 0;
      exp_sel   = 1'b0;
      last_addr = 0;
      seg_ok    = 1'b0;
    end else begin
      ep = '{due: cyc, de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h0};
      if (pin_q.size() > 0 && pin_q[0].due == cyc) ep = pin_q.pop_front();
      chk("de", 32'(de), 32'(ep.de));
      chk("hsync", 32'(hsync), 32'(ep.hs));
      chk("vsync", 32'(vsync), 32'(ep.vs));
      chk("rgb", {8'h0, r_out, g_out, b_out}, {8'h0, ep.rgb});

      e_re = 1'b0;
      if (re_q.size() > 0 && re_q[0].due == cyc) begin
        e_re      = 1'b1;
        last_addr = re_q.pop_front().addr;
      end
      chk("re", 32'(re), 32'(e_re));
      chk("addr", 32'(addr), last_addr);

      e_fd  = 1'b0;
      e_ack = 1'b0;
      if (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
        e_fd  = 1'b1;
        e_ack = ctl_q.pop_front().ack;
      end
      if (e_ack) exp_sel = ~exp_sel;
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("swap_ack", 32'(swap_ack), 32'(e_ack));
      chk("buf_sel", 32'(buf_sel), 32'(exp_sel));

      // Frame-level properties between consecutive frame_done pulses.
      if (re) re_cnt++;
      if (frame_done) begin
        if (!pat_seen) chk("last_frame_addr", 32'(addr), 9999);
        if (seg_ok && !pat_seen) begin
          chk("frame_period", cyc - last_fd_cyc, FRAME);
          chk("re_per_frame", re_cnt, 10000);
        end
        last_fd_cyc = cyc;
        re_cnt      = 0;
        seg_ok      = 1'b1;
        pat_seen    = 1'b0;
      end

      if (en) begin
        h       = k % HT;
        v       = k / HT;
        act_pos = (h < HA) && (v < VA);
        a       = v * HA + h;
        aw      = 20'(a);
        hs_e    = !((h >= HA + 4) && (h < HA + 4 + 8));
        vs_e    = !((v >= VA + 2) && (v < VA + 2 + 2));
        pix     = 24'h0;
        if (act_pos) begin
          if (pat_sel) pix = bars[(h * 8) / HA];
          else begin
            pix = {aw[7:0], aw[15:8], 8'h5A};
            re_q.push_back('{due: cyc + 1, addr: a});
          end
        end
        pin_q.push_back('{due: cyc + 3, de: act_pos, hs: hs_e, vs: vs_e, rgb: pix});
        if (k == FRAME - 1) ctl_q.push_back('{due: cyc + 1, ack: swap_req});
        k = (k + 1) % FRAME;
        if (pat_sel) pat_seen = 1'b1;
      end else begin
        pin_q.push_back('{due: cyc + 3, de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h0});
        k      = 0;
        seg_ok = 1'b0;
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; k = 0; last_addr = 0; exp_sel = 1'b0;
    last_fd_cyc = 0; re_cnt = 0; seg_ok = 1'b0; pat_seen = 1'b0;
    rst_n = 1'b0; en = 1'b0; swap_req = 1'b0; pat_sel = 1'b0;
    step(4);
    rst_n = 1'b1;
    step(3);
    en = 1'b1;
    // Two full frames without a request: no toggle expected.
    step(2 * FRAME + 300);
    // Request raised mid-frame, held across the next frame end.
    swap_req = 1'b1;
    step(FRAME);
    for (int i = 0; i < 24; i++) begin
      swap_req = 1'($urandom_range(0, 1));
      step(500);
    end
    swap_req = 1'b0;
    // Restart the scan, then reset at line 50, pixel 30.
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(50 * HT + 30);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(400);
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(100, 3000));
      en = 1'b0;
      step($urandom_range(1, 12));
      en = 1'b1;
    end
`ifdef SCANOUT_TESTPATTERN_EN
    en = 1'b0;
    step(2);
    pat_sel = 1'b1;
    en      = 1'b1;
    step(3 * HT);
    pat_sel = 1'b0;
`endif
    step(500);
    en = 1'b0;
    step(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
